// File: rtl/pe_weight_load_ctrl_if.sv
// Signal bundle between the weight-load sequencer and its surroundings.
// master: the sequencer itself; slave: upstream source, weight buffer and PE side.
interface pe_weight_load_ctrl_if;
   logic        start;
   logic        src_vld;
   logic [31:0] src_data;
   logic        src_rdy;
   logic        act_ready;
   logic        wr_sop;
   logic        wr_eop;
   logic        wr_vld;
   logic [31:0] wr_data;
   logic        rd_sop;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      input  start, src_vld, src_data, act_ready,
      output src_rdy, wr_sop, wr_eop, wr_vld, wr_data, rd_sop, busy, done, err
   );

   modport slave (
      output start, src_vld, src_data, act_ready,
      input  src_rdy, wr_sop, wr_eop, wr_vld, wr_data, rd_sop, busy, done, err
   );
endinterface

// File: rtl/pe_weight_load_ctrl.sv
// Weight-load sequencer: frames NUM_BEATS upstream beats into one write burst,
// waits for act_ready, fires rd_sop and times the compute window. Optional load
// timeout is compiled in with PE_WLOAD_TIMEOUT_EN.
module pe_weight_load_ctrl #(
   parameter int NUM_BEATS = 36,
   parameter int BEAT_W    = 6,
   parameter int RD_CYCLES = 16
`ifdef PE_WLOAD_TIMEOUT_EN
   ,
   parameter int TIMEOUT   = 255
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   pe_weight_load_ctrl_if.master bus
);

   localparam int WIN_W = $clog2(RD_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_ACT,
      S_COMPUTE,
      S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [BEAT_W-1:0]  beat_cnt;
   logic [WIN_W-1:0]   win_cnt;
   logic               accept;
   logic               last_beat;
   logic               win_last;
   logic               timeout;
   logic               wr_vld_q, wr_sop_q, wr_eop_q, rd_sop_q;
   logic [31:0]        wr_data_q;

   assign accept    = bus.src_vld && (state == S_LOAD);
   assign last_beat = (beat_cnt == BEAT_W'(NUM_BEATS - 1));
   assign win_last  = (win_cnt == WIN_W'(RD_CYCLES - 1));

`ifdef PE_WLOAD_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   logic [IDLE_W-1:0] idle_cnt;

   // Counts consecutive LOAD cycles without an accepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             idle_cnt <= '0;
      else if (state != S_LOAD || accept)  idle_cnt <= '0;
      else                                 idle_cnt <= idle_cnt + IDLE_W'(1);
   end

   assign timeout = (state == S_LOAD) && !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (bus.start) state_nxt = S_LOAD;
         S_LOAD: begin
            if (accept && last_beat) state_nxt = S_WAIT_ACT;
            else if (timeout)        state_nxt = S_IDLE;
         end
         S_WAIT_ACT: if (bus.act_ready) state_nxt = S_COMPUTE;
         S_COMPUTE:  if (win_last) state_nxt = S_DONE;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Write path is one register stage behind the source handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt  <= '0;
         win_cnt   <= '0;
         wr_vld_q  <= 1'b0;
         wr_sop_q  <= 1'b0;
         wr_eop_q  <= 1'b0;
         wr_data_q <= '0;
         rd_sop_q  <= 1'b0;
      end else begin
         wr_vld_q <= accept;
         wr_sop_q <= accept && (beat_cnt == '0);
         wr_eop_q <= accept && last_beat;
         if (accept) wr_data_q <= bus.src_data;
         rd_sop_q <= (state == S_WAIT_ACT) && bus.act_ready;

         if (state == S_IDLE && bus.start) beat_cnt <= '0;
         else if (accept)                  beat_cnt <= beat_cnt + BEAT_W'(1);

         if (state == S_COMPUTE) win_cnt <= win_cnt + WIN_W'(1);
         else                    win_cnt <= '0;
      end
   end

   assign bus.src_rdy = (state == S_LOAD);
   assign bus.wr_vld  = wr_vld_q;
   assign bus.wr_sop  = wr_sop_q;
   assign bus.wr_eop  = wr_eop_q;
   assign bus.wr_data = wr_data_q;
   assign bus.rd_sop  = rd_sop_q;
   assign bus.busy    = (state != S_IDLE);
   assign bus.done    = (state == S_DONE);
   assign bus.err     = timeout;

endmodule

// File: tb/tb_pe_weight_load_ctrl.sv
// Scoreboard bench for pe_weight_load_ctrl: stimulus pushes expected beats and
// pulse cycles, a negedge monitor pops and compares. Honours PE_WLOAD_TIMEOUT_EN.
module tb_pe_weight_load_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pe_weight_load_ctrl_if bus ();

   pe_weight_load_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      int          cyc;
   } beat_t;

   beat_t wq[$];
   int    rq[$];
   int    dq[$];
   int    eq[$];
   int    cyc    = 0;
   int    n_chk  = 0;
   int    n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexp(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got unexpected pulse at cycle %0d required none", name, cyc);
   endtask

   // Monitor: every DUT output event is matched against the scoreboard.
   always @(negedge clk) begin
      beat_t e;
      if (bus.wr_vld) begin
         if (wq.size() == 0) unexp("wr_beat");
         else begin
            e = wq.pop_front();
            chk("wr_beat", {bus.wr_data, bus.wr_sop, bus.wr_eop}, {e.data, e.sop, e.eop});
            chk("wr_cycle", cyc, e.cyc);
         end
      end else if (bus.wr_sop || bus.wr_eop) unexp("wr_sop_eop_no_vld");
      if (bus.rd_sop) begin
         if (rq.size() == 0) unexp("rd_sop");
         else chk("rd_sop_cycle", cyc, rq.pop_front());
      end
      if (bus.done) begin
         if (dq.size() == 0) unexp("done");
         else chk("done_cycle", cyc, dq.pop_front());
      end
      if (bus.err) begin
         if (eq.size() == 0) unexp("err");
         else chk("err_cycle", cyc, eq.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick();
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {bus.wr_vld, bus.wr_sop, bus.wr_eop, bus.rd_sop, bus.busy,
                 bus.done, bus.err, bus.src_rdy, bus.wr_data}, 0);
   endtask

   task automatic chk_empty(input string name);
      chk(name, wq.size() + rq.size() + dq.size() + eq.size(), 0);
   endtask

   task automatic present(input logic [31:0] d, input bit sop, input bit eop);
      beat_t b;
      bus.src_vld  = 1'b1;
      bus.src_data = d;
      b.data = d; b.sop = sop; b.eop = eop; b.cyc = cyc + 1;
      wq.push_back(b);
   endtask

   // act_delay < 0: act_ready high from the start; else raised act_delay cycles after wr_eop.
   task automatic run_job(input logic [31:0] base, input bit gap, input int act_delay,
                          input bit start_noise);
      int s0, r;
      bus.act_ready = (act_delay < 0);
      bus.start = 1'b1;
      tick();
      s0 = cyc;
      bus.start = 1'b0;
      for (int i = 0; i < 36; i++) begin
         present(base + 32'(i), i == 0, i == 35);
         if (start_noise && i == 10) bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         if (gap && i != 35) begin
            bus.src_vld = 1'b0;
            tick();
         end
      end
      bus.src_vld = 1'b0;
      if (act_delay < 0) r = s0 + (gap ? 72 : 37);
      else begin
         wait_cyc(s0 + 36 + act_delay);
         bus.act_ready = 1'b1;
         r = s0 + 36 + act_delay + 1;
      end
      rq.push_back(r);
      dq.push_back(r + 16);
      if (act_delay >= 0) begin
         wait_cyc(r + 2);
         bus.act_ready = 1'b0;
      end
      if (start_noise) begin
         wait_cyc(r + 3);
         bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
      end
      wait_cyc(r + 16);
      chk("busy_in_done", bus.busy, 1);
      tick();
      chk("busy_after_done", bus.busy, 0);
      bus.act_ready = 1'b0;
      tick();
      chk_empty("job_drained");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0, e;
      bus.start     = 1'b0;
      bus.src_vld   = 1'b0;
      bus.src_data  = '0;
      bus.act_ready = 1'b0;
      #3;
      chk_all_zero("reset_outputs");
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk_all_zero("idle_outputs");

      run_job(32'h0,   1'b0, -1, 1'b0);  // continuous beats
      run_job(32'h100, 1'b1, -1, 1'b0);  // valid toggling
      run_job(32'h200, 1'b0, 20, 1'b0);  // late act_ready
      run_job(32'h300, 1'b0, -1, 1'b1);  // start noise while busy

      // Reset in the middle of a burst.
      bus.act_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 17; i++) begin
         present(32'h400 + 32'(i), i == 0, 1'b0);
         tick();
      end
      rst = 1'b1;
      bus.src_vld = 1'b0;
      #1;
      chk_all_zero("mid_burst_reset");
      chk("partial_beats_pending", wq.size(), 1);
      wq.delete();
      tick();
      tick();
      rst = 1'b0;
      tick();
      run_job(32'hA000, 1'b0, -1, 1'b0);

      // Stall after beat 5.
      bus.act_ready = 1'b1;
      bus.start = 1'b1;
      tick();
      s0 = cyc;
      bus.start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         present(32'h500 + 32'(i), i == 0, 1'b0);
         tick();
      end
      bus.src_vld = 1'b0;
`ifdef PE_WLOAD_TIMEOUT_EN
      eq.push_back(s0 + 260);
      wait_cyc(s0 + 260);
      chk("busy_at_err", bus.busy, 1);
      tick();
      chk("busy_after_err", bus.busy, 0);
      chk("src_rdy_after_err", bus.src_rdy, 0);
      repeat (20) tick();
      chk_empty("timeout_drained");
`else
      wait_cyc(s0 + 300);
      chk("busy_while_stalled", bus.busy, 1);
      chk("src_rdy_while_stalled", bus.src_rdy, 1);
      for (int i = 6; i < 36; i++) begin
         present(32'h500 + 32'(i), 1'b0, i == 35);
         tick();
      end
      bus.src_vld = 1'b0;
      e = cyc;
      rq.push_back(e + 1);
      dq.push_back(e + 17);
      wait_cyc(e + 18);
      chk("busy_after_stall_job", bus.busy, 0);
      tick();
      chk_empty("stall_job_drained");
`endif

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
